hamming_serial_decoder: RTL and testbench

Parametrised, single-clock, serial-in/serial-out Hamming decoder for (2^R−1, 2^R−1−R) codes. Incoming codeword bits are collected, the syndrome is computed, a single-bit error is corrected, and the K data bits are re-serialised with per-frame error status and a saturating corrected-error counter. It replaces the fixed (15,11) two-clock decoder datapath on the receive side of the link.

---
 rtl/hamming_pkg.sv | 40 ++++
 rtl/hamming_syndrome_corrector.sv | 67 ++++++
 rtl/hamming_serial_decoder.sv | 115 +++++++++++
 tb/tb_hamming_serial_decoder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared helpers and constants for the serial Hamming decoder
//
// Purpose: code-geometry functions (N, K), power-of-two test, data-index to
// codeword-position mapping, and the bit ordering of the decoder status vector.
// Ports: none (package).
package hamming_pkg;

  localparam int STAT_CORR   = 0;  // single error corrected (or overall parity bit flipped)
  localparam int STAT_DOUBLE = 1;  // uncorrectable error detected
  localparam int STAT_W      = 2;

  function automatic int calc_n(input int r);
    return (1 << r) - 1;
  endfunction

  function automatic int calc_k(input int r);
    return calc_n(r) - r;
  endfunction

  function automatic bit is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  // Codeword position (1-based) carrying data bit idx: data bits fill the
  // non-power-of-two positions in ascending order.
  function automatic int data_pos(input int idx);
    int pos;
    int cnt;
    pos = 0;
    cnt = 0;
    for (int p = 1; p < 128; p++) begin
      if (!is_pow2(p)) begin
        if (cnt == idx && pos == 0) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/hamming_syndrome_corrector.sv
// rtl/hamming_syndrome_corrector.sv - combinational syndrome, single-error correction and data extraction
//
// Purpose: maps a captured frame to its K corrected data bits, syndrome and status.
// Build option: HAMMING_DED_EN adds the overall-parity bit (frame is N+1 bits) and
// double-error detection; undefined gives plain SEC with a frame of N bits.
// Ports:
//   frame    in  F   frame[i] holds codeword position i+1 (frame[N] = overall parity in DED)
//   data     out K   corrected data bits, data[0] from the lowest data position
//   syndrome out R   XOR of the positions of all set bits in 1..N
//   status   out 2   {double, corrected}, ordered by STAT_* in hamming_pkg
module hamming_syndrome_corrector
  import hamming_pkg::*;
#(
  parameter int R = 4
) (
`ifdef HAMMING_DED_EN
  input  logic [calc_n(R):0]         frame,
`else
  input  logic [calc_n(R)-1:0]       frame,
`endif
  output logic [calc_k(R)-1:0]       data,
  output logic [R-1:0]               syndrome,
  output logic [STAT_W-1:0]          status
);

  localparam int N = calc_n(R);
  localparam int K = calc_k(R);

  logic [N-1:0] fixed;
  logic         do_fix;

  always_comb begin
    syndrome = '0;
    for (int i = 0; i < N; i++) begin
      if (frame[i]) syndrome = syndrome ^ R'(i + 1);
    end

    status = '0;
    do_fix = 1'b0;
`ifdef HAMMING_DED_EN
    // Odd overall parity means exactly one flipped bit; a zero syndrome then
    // points at the parity bit itself, so the data needs no change.
    if (^frame) begin
      status[STAT_CORR] = 1'b1;
      do_fix = (syndrome != '0);
    end else if (syndrome != '0) begin
      status[STAT_DOUBLE] = 1'b1;
    end
`else
    if (syndrome != '0) begin
      status[STAT_CORR] = 1'b1;
      do_fix = 1'b1;
    end
`endif

    fixed = frame[N-1:0];
    for (int i = 0; i < N; i++) begin
      if (do_fix && syndrome == R'(i + 1)) fixed[i] = ~fixed[i];
    end
  end

  for (genvar j = 0; j < K; j++) begin : g_extract
    localparam int P = data_pos(j);
    assign data[j] = fixed[P-1];
  end

endmodule

// File: rtl/hamming_serial_decoder.sv
// rtl/hamming_serial_decoder.sv - serial-in/serial-out Hamming (2^R-1, 2^R-1-R) decoder
//
// Purpose: collects codeword bits, decodes/corrects a frame, and re-serialises the
// K data bits with per-frame status and a saturating corrected-frame counter.
// Build option: HAMMING_DED_EN selects SEC-DED (frame = N+1 bits); default is SEC.
// Ports:
//   clk            in   1      rising-edge clock
//   rest           in   1      asynchronous active-low reset
//   device_en      in   1      enable; low discards a partial input frame
//   serial_in      in   1      codeword bit, position 1 first
//   in_valid       in   1      serial_in accepted when in_valid && device_en
//   serial_out     out  1      decoded data bit, data bit 0 first
//   out_valid      out  1      serial_out carries a data bit (K cycles per frame)
//   err_corrected  out  1      last frame had a corrected single error
//   err_double     out  1      last frame had an uncorrectable error (0 in SEC build)
//   syndrome       out  R      syndrome of the last frame
//   corr_count     out  CNT_W  saturating count of corrected frames
module hamming_serial_decoder
  import hamming_pkg::*;
#(
  parameter int R     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             device_en,
  input  logic             serial_in,
  input  logic             in_valid,
  output logic             serial_out,
  output logic             out_valid,
  output logic             err_corrected,
  output logic             err_double,
  output logic [R-1:0]     syndrome,
  output logic [CNT_W-1:0] corr_count
);

  localparam int N = calc_n(R);
  localparam int K = calc_k(R);
`ifdef HAMMING_DED_EN
  localparam int F = N + 1;
`else
  localparam int F = N;
`endif
  localparam int BC_W = $clog2(F);
  localparam int DC_W = $clog2(K + 1);

  logic [F-1:0]      frame_sr;
  logic [BC_W-1:0]   bit_cnt;
  logic              frame_done;
  logic [K-1:0]      out_sr;
  logic [DC_W-1:0]   drain_cnt;

  logic [K-1:0]      dec_data;
  logic [R-1:0]      dec_syn;
  logic [STAT_W-1:0] dec_stat;

  // Input stage: new bits enter at the top so that after F accepted bits the
  // first one (position 1) sits at frame_sr[0].
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      frame_sr   <= '0;
      bit_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (!device_en) begin
        bit_cnt <= '0;
      end else if (in_valid) begin
        frame_sr <= {serial_in, frame_sr[F-1:1]};
        if (bit_cnt == BC_W'(F - 1)) begin
          bit_cnt    <= '0;
          frame_done <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

  // Decoding reads frame_sr during the frame_done cycle; a first bit of the
  // next frame shifting in on that same edge does not disturb the load.
  hamming_syndrome_corrector #(.R(R)) u_corrector (
    .frame    (frame_sr),
    .data     (dec_data),
    .syndrome (dec_syn),
    .status   (dec_stat)
  );

  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      out_sr        <= '0;
      drain_cnt     <= '0;
      syndrome      <= '0;
      err_corrected <= 1'b0;
      err_double    <= 1'b0;
      corr_count    <= '0;
    end else if (frame_done) begin
      out_sr        <= dec_data;
      drain_cnt     <= DC_W'(K);
      syndrome      <= dec_syn;
      err_corrected <= dec_stat[STAT_CORR];
      err_double    <= dec_stat[STAT_DOUBLE];
      if (dec_stat[STAT_CORR] && corr_count != {CNT_W{1'b1}}) begin
        corr_count <= corr_count + 1'b1;
      end
    end else if (drain_cnt != '0) begin
      out_sr    <= out_sr >> 1;
      drain_cnt <= drain_cnt - 1'b1;
    end
  end

  assign serial_out = out_sr[0];
  assign out_valid  = (drain_cnt != '0);

endmodule

// File: tb/tb_hamming_serial_decoder.sv
// tb/tb_hamming_serial_decoder.sv - scoreboard bench for hamming_serial_decoder
module tb_hamming_serial_decoder;

  localparam int R     = 4;
  localparam int CNT_W = 2;
  localparam int N     = 15;
  localparam int K     = 11;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef HAMMING_DED_EN
  localparam int F   = N + 1;
  localparam bit DED = 1'b1;
`else
  localparam int F   = N;
  localparam bit DED = 1'b0;
`endif

  logic             clk;
  logic             rest;
  logic             device_en;
  logic             serial_in;
  logic             in_valid;
  logic             serial_out;
  logic             out_valid;
  logic             err_corrected;
  logic             err_double;
  logic [R-1:0]     syndrome;
  logic [CNT_W-1:0] corr_count;

  hamming_serial_decoder #(.R(R), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rest          (rest),
    .device_en     (device_en),
    .serial_in     (serial_in),
    .in_valid      (in_valid),
    .serial_out    (serial_out),
    .out_valid     (out_valid),
    .err_corrected (err_corrected),
    .err_double    (err_double),
    .syndrome      (syndrome),
    .corr_count    (corr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [K-1:0] data;
    logic [R-1:0] syn;
    logic         corr;
    logic         dbl;
    int           cnt;
    int           start;
  } exp_t;

  exp_t         sb[$];
  exp_t         cur;
  int           tests = 0;
  int           fails = 0;
  int           model_cnt = 0;
  bit           mon_en = 1'b1;
  int           beat = 0;
  logic [K-1:0] rx;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit is_p2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  task automatic send_bit(input logic b, input logic v, input logic en);
    serial_in = b;
    in_valid  = v;
    device_en = en;
    @(posedge clk);
    #1;
  endtask

  // Encode d, flip positions e1/e2 (0 = none), predict the decoder's response
  // from the injected errors, then stream the frame with random idle gaps.
  task automatic send_frame(input logic [K-1:0] d, input int e1, input int e2, input int gap_max);
    logic cw [1:64];
    logic par;
    int   j;
    int   nerr;
    exp_t x;
    j = 0;
    for (int p = 1; p <= N; p++) begin
      if (is_p2(p)) cw[p] = 1'b0;
      else begin
        cw[p] = d[j];
        j++;
      end
    end
    for (int i = 0; i < R; i++) begin
      par = 1'b0;
      for (int p = 1; p <= N; p++) begin
        if (((p >> i) & 1) == 1 && p != (1 << i)) par = par ^ cw[p];
      end
      cw[1 << i] = par;
    end
    if (DED) begin
      par = 1'b0;
      for (int p = 1; p <= N; p++) par = par ^ cw[p];
      cw[F] = par;
    end
    x.syn = '0;
    nerr  = 0;
    if (e1 != 0) begin
      cw[e1] = ~cw[e1];
      nerr++;
      if (e1 <= N) x.syn = x.syn ^ R'(e1);
    end
    if (e2 != 0) begin
      cw[e2] = ~cw[e2];
      nerr++;
      if (e2 <= N) x.syn = x.syn ^ R'(e2);
    end
    if (nerr == 2) begin
      j = 0;
      for (int p = 1; p <= N; p++) begin
        if (!is_p2(p)) begin
          x.data[j] = cw[p];
          j++;
        end
      end
      x.corr = 1'b0;
      x.dbl  = 1'b1;
    end else begin
      x.data = d;
      x.corr = (nerr == 1);
      x.dbl  = 1'b0;
    end
    if (x.corr && model_cnt < CMAX) model_cnt++;
    x.cnt = model_cnt;
    for (int p = 1; p <= F; p++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) send_bit(1'b0, 1'b0, 1'b1);
      send_bit(cw[p], 1'b1, 1'b1);
    end
    x.start = cyc + 1;
    if (mon_en) sb.push_back(x);
  endtask

  // Monitor: pops an expectation at each drain start and checks latency,
  // status, K-cycle valid window and the re-serialised data.
  always @(negedge clk) begin
    if (mon_en) begin
      if (beat == 0) begin
        if (out_valid) begin
          if (sb.size() == 0) begin
            check("unexpected_output", 64'(out_valid), 64'd0);
          end else begin
            cur = sb.pop_front();
            check("latency", 64'(cyc), 64'(cur.start));
            check("syndrome", 64'(syndrome), 64'(cur.syn));
            check("err_corrected", 64'(err_corrected), 64'(cur.corr));
            check("err_double", 64'(err_double), 64'(cur.dbl));
            check("corr_count", 64'(corr_count), 64'(cur.cnt));
            rx[0] = serial_out;
            beat  = 1;
          end
        end
      end else if (beat < K) begin
        check("valid_len", 64'(out_valid), 64'd1);
        rx[beat] = serial_out;
        beat++;
        if (beat == K) check("data", 64'(rx), 64'(cur.data));
      end else begin
        check("valid_end", 64'(out_valid), 64'd0);
        beat = 0;
      end
    end
  end

  logic [K-1:0] rd;
  int           e1;
  int           e2;
  int           t;

  initial begin
    rest      = 1'b0;
    device_en = 1'b0;
    serial_in = 1'b0;
    in_valid  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_serial_out", 64'(serial_out), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_err_corrected", 64'(err_corrected), 64'd0);
    check("rst_err_double", 64'(err_double), 64'd0);
    check("rst_syndrome", 64'(syndrome), 64'd0);
    check("rst_corr_count", 64'(corr_count), 64'd0);
    rest = 1'b1;
    send_bit(1'b0, 1'b0, 1'b1);

    send_frame('0, 0, 0, 0);
    send_frame('0, 5, 0, 0);
`ifdef HAMMING_DED_EN
    send_frame(11'h7FF, 3, 5, 0);
    send_frame(11'h7FF, 16, 0, 0);
`endif
    rd = K'($urandom());
    send_frame(rd, 0, 0, 3);

    // Partial frame cut by a DEVICE_EN pulse must be discarded.
    for (int i = 0; i < 7; i++) send_bit(1'($urandom()), 1'b1, 1'b1);
    send_bit(1'b1, 1'b1, 1'b0);
    rd = K'($urandom());
    send_frame(rd, 0, 0, 0);

    for (int i = 0; i < 5; i++) begin
      rd = K'($urandom());
      send_frame(rd, $urandom_range(1, F), 0, 0);
    end

    for (int i = 0; i < 40; i++) begin
      rd = K'($urandom());
      e1 = 0;
      e2 = 0;
      case ($urandom_range(0, DED ? 2 : 1))
        1: e1 = $urandom_range(1, F);
        2: begin
          e1 = $urandom_range(1, F);
          do e2 = $urandom_range(1, F); while (e2 == e1);
        end
        default: ;
      endcase
      send_frame(rd, e1, e2, $urandom_range(0, 2));
    end

    t = 0;
    while ((sb.size() != 0 || beat != 0) && t < 500) begin
      send_bit(1'b0, 1'b0, 1'b1);
      t++;
    end
    check("drain_done", 64'(sb.size() == 0 && beat == 0), 64'd1);

    // Reset in the middle of a drain clears every output at once.
    mon_en = 1'b0;
    rd = K'($urandom());
    send_frame(rd, 3, 0, 0);
    t = 0;
    while (!out_valid && t < 20) begin
      send_bit(1'b0, 1'b0, 1'b1);
      t++;
    end
    check("drain_started", 64'(out_valid), 64'd1);
    repeat (3) @(negedge clk);
    #2;
    rest = 1'b0;
    #1;
    check("mid_rst_serial_out", 64'(serial_out), 64'd0);
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_err_corrected", 64'(err_corrected), 64'd0);
    check("mid_rst_syndrome", 64'(syndrome), 64'd0);
    check("mid_rst_corr_count", 64'(corr_count), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
